toll_controller: RTL and testbench

TOLL_CONTROLLER -- requirements
Module: toll_controller

---
 rtl/toll_controller.sv | 99 +++++++++
 tb/tb_toll_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/toll_controller.sv
// Toll booth barrier controller driven by decoded UART event codes.
// Edge-detects the event stream and runs an IDLE/OPEN/ALERT FSM with hold timeouts.
module toll_controller #(
  parameter int GATE_HOLD  = 16,
  parameter int ALERT_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] uart_data,
  output logic       gate_open,
  output logic       tailgate_alert,
  output logic       ev_discount
);

  localparam int MAX_HOLD = (GATE_HOLD > ALERT_HOLD) ? GATE_HOLD : ALERT_HOLD;
  localparam int CW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] GATE_LAST  = CW'(GATE_HOLD - 1);
  localparam logic [CW-1:0] ALERT_LAST = CW'(ALERT_HOLD - 1);

  localparam logic [2:0] CODE_TAG    = 3'd1;
  localparam logic [2:0] CODE_EV_TAG = 3'd2;
  localparam logic [2:0] CODE_NO_TAG = 3'd3;
  localparam logic [2:0] CODE_EXIT   = 3'd4;
  localparam logic [2:0] CODE_CLEAR  = 3'd5;

  typedef enum logic [1:0] {IDLE, OPEN, ALERT} state_t;

  state_t        state;
  logic [2:0]    prev;
  logic [CW-1:0] cnt;
  logic          accept;

  // Reserved codes never count as events, but prev still tracks them.
  assign accept = (uart_data != prev) && (uart_data != 3'd0) && (uart_data <= CODE_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      prev           <= 3'd0;
      cnt            <= '0;
      gate_open      <= 1'b0;
      tailgate_alert <= 1'b0;
      ev_discount    <= 1'b0;
    end else begin
      prev <= uart_data;
      case (state)
        IDLE: begin
          if (accept && (uart_data == CODE_TAG || uart_data == CODE_EV_TAG)) begin
            state          <= OPEN;
            cnt            <= '0;
            gate_open      <= 1'b1;
            tailgate_alert <= 1'b0;
            ev_discount    <= (uart_data == CODE_EV_TAG);
          end
        end
        OPEN: begin
          if (accept && uart_data == CODE_EXIT) begin
            state       <= IDLE;
            cnt         <= '0;
            gate_open   <= 1'b0;
            ev_discount <= 1'b0;
          end else if (accept && (uart_data == CODE_TAG || uart_data == CODE_EV_TAG ||
                                  uart_data == CODE_NO_TAG)) begin
            state          <= ALERT;
            cnt            <= '0;
            gate_open      <= 1'b0;
            tailgate_alert <= 1'b1;
            ev_discount    <= 1'b0;
          end else if (cnt == GATE_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            gate_open   <= 1'b0;
            ev_discount <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ALERT: begin
          // A clear event and the hold timeout lead to the same place.
          if ((accept && uart_data == CODE_CLEAR) || cnt == ALERT_LAST) begin
            state          <= IDLE;
            cnt            <= '0;
            tailgate_alert <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          cnt            <= '0;
          gate_open      <= 1'b0;
          tailgate_alert <= 1'b0;
          ev_discount    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toll_controller.sv
// Directed bench for toll_controller; outputs compared as {gate_open, tailgate_alert, ev_discount}.
module tb_toll_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] uart_data = 3'd0;
  logic       gate_open;
  logic       tailgate_alert;
  logic       ev_discount;

  int checks = 0;
  int failures = 0;

  toll_controller #(.GATE_HOLD(16), .ALERT_HOLD(8)) dut (
    .clk(clk),
    .reset(reset),
    .uart_data(uart_data),
    .gate_open(gate_open),
    .tailgate_alert(tailgate_alert),
    .ev_discount(ev_discount)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] outs();
    return {gate_open, tailgate_alert, ev_discount};
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive a code on the falling edge, then sample just after the rising edge that consumes it.
  task automatic applyStimulus(input logic [2:0] code);
    @(negedge clk);
    uart_data = code;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int high_cnt;
    int both_cnt;

    reset = 1'b1;
    applyStimulus(3'd0);
    applyStimulus(3'd0);
    checkOutput("reset_state", outs(), 3'b000);
    reset = 1'b0;

    // Plain tag, held for several cycles, then exit
    applyStimulus(3'd1);
    checkOutput("tag_open", outs(), 3'b100);
    applyStimulus(3'd1);
    checkOutput("tag_held1", outs(), 3'b100);
    applyStimulus(3'd1);
    checkOutput("tag_held2", outs(), 3'b100);
    applyStimulus(3'd4);
    checkOutput("tag_exit", outs(), 3'b000);
    applyStimulus(3'd0);

    // EV tag then exit
    applyStimulus(3'd2);
    checkOutput("ev_open", outs(), 3'b101);
    applyStimulus(3'd4);
    checkOutput("ev_exit", outs(), 3'b000);
    applyStimulus(3'd0);

    // Second vehicle before exit raises the alert; clear returns to idle
    applyStimulus(3'd1);
    checkOutput("tg_open", outs(), 3'b100);
    applyStimulus(3'd0);
    checkOutput("tg_gap", outs(), 3'b100);
    applyStimulus(3'd1);
    checkOutput("tg_alert", outs(), 3'b010);
    applyStimulus(3'd5);
    checkOutput("tg_clear", outs(), 3'b000);
    applyStimulus(3'd0);

    // Gate timeout: open for exactly 16 sampled cycles
    high_cnt = 0;
    both_cnt = 0;
    applyStimulus(3'd1);
    if (gate_open) high_cnt++;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(3'd0);
      if (gate_open) high_cnt++;
      if (gate_open && tailgate_alert) both_cnt++;
    end
    checkOutput("gate_hold_len", high_cnt, 16);
    checkOutput("gate_hold_end", outs(), 3'b000);

    // Alert timeout: alert for exactly 8 sampled cycles
    high_cnt = 0;
    applyStimulus(3'd1);
    applyStimulus(3'd2);
    if (tailgate_alert) high_cnt++;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'd2);
      if (tailgate_alert) high_cnt++;
      if (gate_open && tailgate_alert) both_cnt++;
    end
    checkOutput("alert_hold_len", high_cnt, 8);
    checkOutput("alert_hold_end", outs(), 3'b000);
    checkOutput("never_both", both_cnt, 0);
    applyStimulus(3'd0);

    // Event on the same edge as the gate timeout wins
    applyStimulus(3'd1);
    for (int i = 0; i < 15; i++) applyStimulus(3'd0);
    checkOutput("prio_still_open", outs(), 3'b100);
    applyStimulus(3'd3);
    checkOutput("prio_event_wins", outs(), 3'b010);
    applyStimulus(3'd5);
    checkOutput("prio_clear", outs(), 3'b000);
    applyStimulus(3'd0);

    // Ignored codes in idle
    applyStimulus(3'd3);
    checkOutput("idle_code3", outs(), 3'b000);
    applyStimulus(3'd6);
    checkOutput("idle_code6", outs(), 3'b000);
    applyStimulus(3'd7);
    checkOutput("idle_code7", outs(), 3'b000);
    applyStimulus(3'd4);
    checkOutput("idle_code4", outs(), 3'b000);
    applyStimulus(3'd5);
    checkOutput("idle_code5", outs(), 3'b000);

    // Reserved code still updates prev, so a following tag is a fresh event
    applyStimulus(3'd1);
    checkOutput("rsv_open", outs(), 3'b100);
    applyStimulus(3'd6);
    checkOutput("rsv_ignored_open", outs(), 3'b100);
    applyStimulus(3'd5);
    checkOutput("open_code5_ignored", outs(), 3'b100);
    applyStimulus(3'd1);
    checkOutput("rsv_retag_alert", outs(), 3'b010);
    applyStimulus(3'd1);
    checkOutput("alert_tag_ignored", outs(), 3'b010);
    applyStimulus(3'd5);
    checkOutput("rsv_clear", outs(), 3'b000);
    applyStimulus(3'd0);

    // Reset while open, with tag held through and after reset
    applyStimulus(3'd1);
    checkOutput("rst_open", outs(), 3'b100);
    reset = 1'b1;
    applyStimulus(3'd1);
    checkOutput("rst_in_open", outs(), 3'b000);
    reset = 1'b0;
    applyStimulus(3'd1);
    checkOutput("rst_reopen", outs(), 3'b100);
    applyStimulus(3'd4);
    checkOutput("rst_exit", outs(), 3'b000);

    // Reset while in alert
    applyStimulus(3'd2);
    applyStimulus(3'd3);
    checkOutput("rst_alert_pre", outs(), 3'b010);
    reset = 1'b1;
    applyStimulus(3'd5);
    checkOutput("rst_in_alert", outs(), 3'b000);
    reset = 1'b0;
    applyStimulus(3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
